// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared reset/bubble constants and fetch FSM state encoding.
package if_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DISCARD} state_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus.
// Ports: req/addr driven by the fetch stage (master); ready/rdata driven by memory (slave).
interface if_stage_if;
  logic req;
  logic [31:0] addr;
  logic ready;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rdata);
  modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold (keep contents) and flush (load a bubble).
// Ports: clk, rst (async high); hold, flush; pc_in/inst_in captured when neither is set;
//        id_pc/id_inst/id_valid register outputs. A flush keeps id_pc.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);
  logic [31:0] id_pc_d, id_pc_q, id_inst_d, id_inst_q;
  logic id_valid_d, id_valid_q;
  always_comb begin
    id_pc_d = hold || flush ? id_pc_q : pc_in;
    id_inst_d = hold ? id_inst_q : flush ? NOP_INST : inst_in;
    id_valid_d = hold ? id_valid_q : !flush;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_pc_q <= '0;
      id_inst_q <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  assign id_pc = id_pc_q;
  assign id_inst = id_inst_q;
  assign id_valid = id_valid_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage -- PC register, fetch FSM and IF/ID register.
// Ports: clk, rst (async high); npc next PC; load_stall, branch_stall; pc current fetch PC;
//        imem (if_stage_if master); id_pc/id_inst/id_valid IF/ID contents;
//        if_misalign only when IF_MISALIGN_CHK_EN is defined (npc then force-aligned).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        load_stall,
  input  logic        branch_stall,
  output logic [31:0] pc,
  if_stage_if.master  imem,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        if_misalign
`endif
);
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, disc_addr_q, disc_addr_d, npc_eff;
  logic pc_ld, fetch_xfer, id_flush;
  assign fetch_xfer = state_q == S_FETCH && imem.ready;
`ifdef IF_MISALIGN_CHK_EN
  logic if_misalign_d, if_misalign_q;
  assign npc_eff = {npc[31:2], 2'b00};
  assign if_misalign_d = pc_ld && npc[1:0] != 2'b00;
  assign if_misalign = if_misalign_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) if_misalign_q <= 1'b0;
    else if_misalign_q <= if_misalign_d;
`else
  assign npc_eff = npc;
`endif
  // A redirect while a request is outstanding leaves the old address on the
  // bus until memory answers; track pc until then so the abandoned address is frozen.
  always_comb begin
    state_d = state_q;
    pc_ld = 1'b0;
    if (!load_stall) begin
      pc_ld = branch_stall || fetch_xfer;
      state_d = branch_stall && state_q != S_BOOT && !imem.ready ? S_DISCARD :
                !branch_stall && state_q == S_DISCARD && !imem.ready ? S_DISCARD : S_FETCH;
    end
    pc_d = pc_ld ? npc_eff : pc_q;
    disc_addr_d = state_q == S_DISCARD ? disc_addr_q : pc_q;
    id_flush = branch_stall || !fetch_xfer;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_BOOT;
      pc_q <= RESET_PC;
      disc_addr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      disc_addr_q <= disc_addr_d;
    end
  assign pc = pc_q;
  assign imem.req = state_q != S_BOOT;
  assign imem.addr = state_q == S_DISCARD ? disc_addr_q : pc_q;
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
    .clk(clk),
    .rst(rst),
    .hold(load_stall),
    .flush(id_flush),
    .pc_in(pc_q),
    .inst_in(imem.rdata),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_valid(id_valid)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_stall = 1'b0, branch_stall = 1'b0, ready_r = 1'b1, npc_ovr = 1'b0;
  logic [31:0] npc, npc_val = '0, pc, id_pc, id_inst;
  logic id_valid;
  int total = 0, bad = 0;
  if_stage_if bus();
  always #5 clk = ~clk;
  assign npc = npc_ovr ? npc_val : pc + 32'd4;
  assign bus.ready = ready_r;
  assign bus.rdata = bus.addr + 32'h1000_0000;
`ifdef IF_MISALIGN_CHK_EN
  logic if_misalign;
`endif
  if_stage dut (
    .clk(clk),
    .rst(rst),
    .npc(npc),
    .load_stall(load_stall),
    .branch_stall(branch_stall),
    .pc(pc),
    .imem(bus.master),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_valid(id_valid)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .if_misalign(if_misalign)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_id(input string tag, input logic [31:0] p, input logic [31:0] ip,
                        input logic [31:0] inst, input logic v);
    chk({tag, "_pc"}, pc, p);
    chk({tag, "_id_pc"}, id_pc, ip);
    chk({tag, "_id_inst"}, id_inst, inst);
    chk({tag, "_id_valid"}, {31'd0, id_valid}, {31'd0, v});
  endtask
  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk_id("rst", 32'h0, 32'h0, 32'h13, 1'b0);
    step();
    step();
    rst = 1'b0;
    chk("boot_req", {31'd0, bus.req}, 32'd0);
    step();
    chk("fetch_req", {31'd0, bus.req}, 32'd1);
    chk("fetch_addr", bus.addr, 32'h0);
    step();
    chk_id("seq0", 32'h4, 32'h0, 32'h1000_0000, 1'b1);
    step();
    chk_id("seq4", 32'h8, 32'h4, 32'h1000_0004, 1'b1);
    step();
    chk_id("seq8", 32'hC, 32'h8, 32'h1000_0008, 1'b1);
    step();
    chk_id("seqC", 32'h10, 32'hC, 32'h1000_000C, 1'b1);
    ready_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_addr", bus.addr, 32'h10);
      chk_id("wait", 32'h10, 32'hC, 32'h13, 1'b0);
    end
    ready_r = 1'b1;
    step();
    chk_id("late10", 32'h14, 32'h10, 32'h1000_0010, 1'b1);
    step();
    step();
    step();
    step();
    chk_id("pre_ls", 32'h24, 32'h20, 32'h1000_0020, 1'b1);
    load_stall = 1'b1;
    step();
    chk_id("ls1", 32'h24, 32'h20, 32'h1000_0020, 1'b1);
    step();
    chk_id("ls2", 32'h24, 32'h20, 32'h1000_0020, 1'b1);
    chk("ls_addr", bus.addr, 32'h24);
    load_stall = 1'b0;
    step();
    chk_id("ls_resume", 32'h28, 32'h24, 32'h1000_0024, 1'b1);
    load_stall = 1'b1;
    branch_stall = 1'b1;
    npc_ovr = 1'b1;
    npc_val = 32'h200;
    step();
    chk_id("both", 32'h28, 32'h24, 32'h1000_0024, 1'b1);
    load_stall = 1'b0;
    npc_val = 32'h100;
    ready_r = 1'b0;
    step();
    chk_id("br", 32'h100, 32'h24, 32'h13, 1'b0);
    chk("disc_addr", bus.addr, 32'h28);
    chk("disc_req", {31'd0, bus.req}, 32'd1);
    branch_stall = 1'b0;
    npc_ovr = 1'b0;
    step();
    chk("disc_addr2", bus.addr, 32'h28);
    chk_id("disc", 32'h100, 32'h24, 32'h13, 1'b0);
    ready_r = 1'b1;
    step();
    chk_id("drop", 32'h100, 32'h24, 32'h13, 1'b0);
    chk("refetch_addr", bus.addr, 32'h100);
    step();
    chk_id("tgt", 32'h104, 32'h100, 32'h1000_0100, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_req", {31'd0, bus.req}, 32'd0);
    chk_id("arst", 32'h0, 32'h0, 32'h13, 1'b0);
    step();
    rst = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    chk("mis_rst", {31'd0, if_misalign}, 32'd0);
    step();
    branch_stall = 1'b1;
    npc_ovr = 1'b1;
    npc_val = 32'h102;
    ready_r = 1'b0;
    step();
    chk("mis_pc", pc, 32'h100);
    chk("mis_pulse", {31'd0, if_misalign}, 32'd1);
    branch_stall = 1'b0;
    npc_ovr = 1'b0;
    step();
    chk("mis_clear", {31'd0, if_misalign}, 32'd0);
    chk("mis_pc2", pc, 32'h100);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
